// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
// ---------------------------------------------------------------------------
// Sequences all processor traffic to an asynchronous, MFC-handshaked,
// 256-byte big-endian RAM. Two requesters share the RAM:
//   - instruction fetch port (word reads only)
//   - data port (byte/half/word/doubleword, read or write)
// Ties are broken round-robin. Every RAM access is a four-phase handshake:
// raise Enable, wait for MFC, drop Enable, wait for MFC to fall. A
// doubleword is split into two word beats at DAddr and DAddr+4 (mod 256),
// high word first.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   When defined, each handshake phase is limited to TIMEOUT_CYCLES cycles.
//   On expiry the access is abandoned and Done is pulsed together with
//   MemErr, with read data forced to zero. When undefined, the controller
//   waits indefinitely and MemErr is tied low.
//
// Ports
//   Clk, Reset           clock, synchronous active-high reset
//   IReq, IAddr          fetch request (level, held until IDone) and address
//   IData, IDone         fetched word and one-cycle completion pulse
//   DReq, DRW, DSize,    data request (level), 1=read/0=write, size code,
//   DAddr, DWData        byte address, right-justified write data
//   DRData, DDone        zero-extended read data and completion pulse
//   MemErr               handshake timeout flag, pulses with Done
//   MemEnable, MemReadWrite, MemAddress, MemDataIn, MemSize  RAM controls
//   MemDataOut, MFC      RAM read data and asynchronous completion strobe
// ---------------------------------------------------------------------------
module ram_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        Clk,
  input  logic        Reset,
  // instruction fetch port
  input  logic        IReq,
  input  logic [7:0]  IAddr,
  output logic [31:0] IData,
  output logic        IDone,
  // data port
  input  logic        DReq,
  input  logic        DRW,
  input  logic [1:0]  DSize,
  input  logic [7:0]  DAddr,
  input  logic [63:0] DWData,
  output logic [63:0] DRData,
  output logic        DDone,
  output logic        MemErr,
  // RAM side
  output logic        MemEnable,
  output logic        MemReadWrite,
  output logic [7:0]  MemAddress,
  output logic [31:0] MemDataIn,
  output logic [1:0]  MemSize,
  input  logic [31:0] MemDataOut,
  input  logic        MFC
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE  = 2'b00;
  localparam logic [1:0] SIZE_HALF  = 2'b01;
  localparam logic [1:0] SIZE_WORD  = 2'b10;
  localparam logic [1:0] SIZE_DWORD = 2'b11;

  // A zero-length phase limit would abort every access before it starts.
  generate
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("ram_access_ctrl: TIMEOUT_CYCLES must be at least 1");
    end
  endgenerate

  state_t      state_reg;
  logic        mfc_meta_reg;
  logic        mfc_s_reg;
  logic        last_data_reg;   // 1 = data port was granted most recently
  logic        sel_data_reg;    // port owning the current transaction
  logic        rw_reg;
  logic [1:0]  size_reg;
  logic [7:0]  addr_reg;
  logic [31:0] wdata_lo_reg;    // low word, needed only for doubleword beat 1
  logic        beat_reg;
  logic [63:0] rdata_reg;
  logic        pick_data;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] phase_cnt_reg;
  logic             mem_err_reg;
  assign MemErr = mem_err_reg;
`else
  assign MemErr = 1'b0;
`endif

  // MFC comes from the RAM's own timing domain.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mfc_meta_reg <= 1'b0;
      mfc_s_reg    <= 1'b0;
    end else begin
      mfc_meta_reg <= MFC;
      mfc_s_reg    <= mfc_meta_reg;
    end
  end

  // Data wins when it is the only requester, or on a tie when fetch went last.
  assign pick_data = DReq & (~IReq | ~last_data_reg);

  // Merge one RAM read beat into the accumulated read value. Sub-word reads
  // keep only the bits the access actually returned; the RAM leaves stale
  // data in the upper DataOut bits.
  function automatic logic [63:0] merge_read(
    input logic [1:0]  size,
    input logic        beat,
    input logic [63:0] acc,
    input logic [31:0] dout
  );
    logic [63:0] res;
    case (size)
      SIZE_BYTE: res = {56'b0, dout[7:0]};
      SIZE_HALF: res = {48'b0, dout[15:0]};
      SIZE_WORD: res = {32'b0, dout};
      default:   res = beat ? {acc[63:32], dout} : {dout, acc[31:0]};
    endcase
    return res;
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg     <= IDLE;
      last_data_reg <= 1'b0;
      sel_data_reg  <= 1'b0;
      rw_reg        <= 1'b0;
      size_reg      <= 2'b00;
      addr_reg      <= 8'h00;
      wdata_lo_reg  <= 32'h0;
      beat_reg      <= 1'b0;
      rdata_reg     <= 64'h0;
      IData         <= 32'h0;
      IDone         <= 1'b0;
      DRData        <= 64'h0;
      DDone         <= 1'b0;
      MemEnable     <= 1'b0;
      MemReadWrite  <= 1'b0;
      MemAddress    <= 8'h00;
      MemDataIn     <= 32'h0;
      MemSize       <= 2'b00;
`ifdef MEM_TIMEOUT_EN
      phase_cnt_reg <= '0;
      mem_err_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          // Waiting for MFC_s low keeps a RAM that is still finishing an
          // abandoned access from being handed a new one.
          if (!mfc_s_reg && (IReq || DReq)) begin
            state_reg <= ACCESS;
            MemEnable <= 1'b1;
            beat_reg  <= 1'b0;
            rdata_reg <= 64'h0;
`ifdef MEM_TIMEOUT_EN
            phase_cnt_reg <= '0;
`endif
            if (pick_data) begin
              sel_data_reg  <= 1'b1;
              last_data_reg <= 1'b1;
              rw_reg        <= DRW;
              size_reg      <= DSize;
              addr_reg      <= DAddr;
              wdata_lo_reg  <= DWData[31:0];
              MemReadWrite  <= DRW;
              MemAddress    <= DAddr;
              // The RAM only knows up to word size; a doubleword goes out
              // as two word beats, high word first.
              MemSize       <= (DSize == SIZE_DWORD) ? SIZE_WORD : DSize;
              MemDataIn     <= (DSize == SIZE_DWORD) ? DWData[63:32] : DWData[31:0];
            end else begin
              sel_data_reg  <= 1'b0;
              last_data_reg <= 1'b0;
              rw_reg        <= 1'b1;
              size_reg      <= SIZE_WORD;
              addr_reg      <= IAddr;
              wdata_lo_reg  <= 32'h0;
              MemReadWrite  <= 1'b1;
              MemAddress    <= IAddr;
              MemSize       <= SIZE_WORD;
              MemDataIn     <= 32'h0;
            end
          end
        end

        ACCESS: begin
          if (mfc_s_reg) begin
            MemEnable <= 1'b0;
            state_reg <= RELEASE;
            if (rw_reg) begin
              rdata_reg <= merge_read(size_reg, beat_reg, rdata_reg, MemDataOut);
            end
`ifdef MEM_TIMEOUT_EN
            phase_cnt_reg <= '0;
          end else if (phase_cnt_reg == CNT_LAST) begin
            // Abandon the access: report the error with zero data.
            MemEnable   <= 1'b0;
            state_reg   <= DONE;
            mem_err_reg <= 1'b1;
            IDone       <= ~sel_data_reg;
            DDone       <= sel_data_reg;
            if (sel_data_reg) DRData <= 64'h0;
            else              IData  <= 32'h0;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + CNT_W'(1);
`endif
          end
        end

        RELEASE: begin
          if (!mfc_s_reg) begin
            if (size_reg == SIZE_DWORD && !beat_reg) begin
              beat_reg   <= 1'b1;
              state_reg  <= ACCESS;
              MemEnable  <= 1'b1;
              MemAddress <= addr_reg + 8'd4;
              MemDataIn  <= wdata_lo_reg;
            end else begin
              state_reg <= DONE;
              IDone     <= ~sel_data_reg;
              DDone     <= sel_data_reg;
              // rdata_reg is cleared at grant and only filled on reads, so a
              // completed write reports zero.
              if (sel_data_reg) DRData <= rdata_reg;
              else              IData  <= rdata_reg[31:0];
            end
`ifdef MEM_TIMEOUT_EN
            phase_cnt_reg <= '0;
          end else if (phase_cnt_reg == CNT_LAST) begin
            // Enable is already low; any pending doubleword beat is dropped.
            state_reg   <= DONE;
            mem_err_reg <= 1'b1;
            IDone       <= ~sel_data_reg;
            DDone       <= sel_data_reg;
            if (sel_data_reg) DRData <= 64'h0;
            else              IData  <= 32'h0;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + CNT_W'(1);
`endif
          end
        end

        DONE: begin
          IDone     <= 1'b0;
          DDone     <= 1'b0;
          state_reg <= IDLE;
`ifdef MEM_TIMEOUT_EN
          mem_err_reg <= 1'b0;
`endif
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl
// ---------------------------------------------------------------------------
// Self-checking bench for ram_access_ctrl. A behavioural asynchronous RAM
// answers Enable with MFC after random delays. Expected results come from a
// separate byte-array reference memory updated with the big-endian access
// rules. Directed cases come first (reset, stuck MFC, arbitration, fetch,
// doubleword wrap, stale DataOut), then randomized single-port traffic.
// Build with MEM_TIMEOUT_EN defined to exercise the timeout path.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ram_access_ctrl;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [7:0]  fetch_addr;
  logic [31:0] fetch_data;
  logic        fetch_done;
  logic        data_req;
  logic        data_rw;
  logic [1:0]  data_size;
  logic [7:0]  data_addr;
  logic [63:0] data_wdata;
  logic [63:0] data_rdata;
  logic        data_done;
  logic        mem_err;
  logic        mem_enable;
  logic        mem_rw;
  logic [7:0]  mem_address;
  logic [31:0] mem_data_in;
  logic [1:0]  mem_size;
  logic [31:0] mem_data_out;
  logic        mfc;

  ram_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .Clk(clk), .Reset(reset),
    .IReq(fetch_req), .IAddr(fetch_addr), .IData(fetch_data), .IDone(fetch_done),
    .DReq(data_req), .DRW(data_rw), .DSize(data_size), .DAddr(data_addr),
    .DWData(data_wdata), .DRData(data_rdata), .DDone(data_done), .MemErr(mem_err),
    .MemEnable(mem_enable), .MemReadWrite(mem_rw), .MemAddress(mem_address),
    .MemDataIn(mem_data_in), .MemSize(mem_size), .MemDataOut(mem_data_out), .MFC(mfc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- RAM contents ----------------
  function automatic logic [7:0] init_byte(input int i);
    case (i)
      'h05: return 8'h7E;
      'h10: return 8'h11;
      'h11: return 8'h22;
      'h12: return 8'h33;
      'h13: return 8'h44;
      'h20: return 8'hAA;
      'h21: return 8'hBB;
      'h22: return 8'hCC;
      'h23: return 8'hDD;
      default: return 8'((i * 73 + 29) ^ (i >> 3));
    endcase
  endfunction

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] din;
    logic [1:0]  size;
    logic        rw;
  } beat_t;

  logic [7:0] ram [256];
  beat_t      beats[$];
  int         bad_size = 0;
  bit         mfc_stuck = 1'b0;

  // Behavioural RAM: performs the access and raises MFC some cycles after
  // Enable, drops MFC some cycles after Enable falls. Sub-word reads only
  // refresh the low DataOut bits.
  initial begin
    int delay;
    logic [7:0] a0, a1, a2, a3;
    for (int i = 0; i < 256; i++) ram[i] = init_byte(i);
    mfc = 1'b0;
    mem_data_out = 32'h0;
    delay = 0;
    forever begin
      @(posedge clk); #3;
      if (mem_enable && !mfc && !mfc_stuck) begin
        if (delay > 0) delay--;
        else begin
          a0 = mem_address; a1 = a0 + 8'd1; a2 = a0 + 8'd2; a3 = a0 + 8'd3;
          beats.push_back('{addr: mem_address, din: mem_data_in, size: mem_size, rw: mem_rw});
          if (mem_size == 2'b11) bad_size++;
          if (mem_rw) begin
            case (mem_size)
              2'b00:   mem_data_out[7:0]  = ram[a0];
              2'b01:   mem_data_out[15:0] = {ram[a0], ram[a1]};
              default: mem_data_out       = {ram[a0], ram[a1], ram[a2], ram[a3]};
            endcase
          end else begin
            case (mem_size)
              2'b00: ram[a0] = mem_data_in[7:0];
              2'b01: begin ram[a0] = mem_data_in[15:8]; ram[a1] = mem_data_in[7:0]; end
              default: begin
                ram[a0] = mem_data_in[31:24]; ram[a1] = mem_data_in[23:16];
                ram[a2] = mem_data_in[15:8];  ram[a3] = mem_data_in[7:0];
              end
            endcase
          end
          mfc = 1'b1;
          delay = $urandom_range(0, 2);
        end
      end else if (!mem_enable && mfc) begin
        if (delay > 0) delay--;
        else begin
          mfc = 1'b0;
          delay = $urandom_range(0, 2);
        end
      end
    end
  end

  // Activity counters, sampled just after the rising edge.
  int en_cycles = 0;
  int done_pulses = 0;
  always @(posedge clk) begin
    #1;
    if (mem_enable) en_cycles++;
    if (fetch_done || data_done) done_pulses++;
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [256];
  bit model_last_data = 1'b0;

  function automatic logic [31:0] ref_word(input logic [7:0] a);
    return {ref_mem[a], ref_mem[8'(a + 8'd1)], ref_mem[8'(a + 8'd2)], ref_mem[8'(a + 8'd3)]};
  endfunction

  function automatic logic [63:0] ref_read(input logic [1:0] size, input logic [7:0] a);
    case (size)
      2'b00:   return {56'b0, ref_mem[a]};
      2'b01:   return {48'b0, ref_mem[a], ref_mem[8'(a + 8'd1)]};
      2'b10:   return {32'b0, ref_word(a)};
      default: return {ref_word(a), ref_word(8'(a + 8'd4))};
    endcase
  endfunction

  task automatic ref_put_word(input logic [7:0] a, input logic [31:0] w);
    ref_mem[a] = w[31:24];
    ref_mem[8'(a + 8'd1)] = w[23:16];
    ref_mem[8'(a + 8'd2)] = w[15:8];
    ref_mem[8'(a + 8'd3)] = w[7:0];
  endtask

  task automatic ref_write(input logic [1:0] size, input logic [7:0] a, input logic [63:0] wd);
    case (size)
      2'b00: ref_mem[a] = wd[7:0];
      2'b01: begin ref_mem[a] = wd[15:8]; ref_mem[8'(a + 8'd1)] = wd[7:0]; end
      2'b10: ref_put_word(a, wd[31:0]);
      default: begin ref_put_word(a, wd[63:32]); ref_put_word(8'(a + 8'd4), wd[31:0]); end
    endcase
  endtask

  // ---------------- transaction tasks ----------------
  // Request inputs are scrambled once the grant has been taken; the
  // transaction must run on the latched values.
  task automatic data_txn(input logic rw, input logic [1:0] size, input logic [7:0] addr,
                          input logic [63:0] wd, output logic [63:0] rd, output bit seen);
    @(negedge clk);
    data_req = 1'b1; data_rw = rw; data_size = size; data_addr = addr; data_wdata = wd;
    seen = 1'b0; rd = 64'h0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) begin
        data_addr = 8'($urandom); data_wdata = {$urandom, $urandom};
        data_rw = 1'($urandom); data_size = 2'($urandom);
      end
      if (data_done) begin seen = 1'b1; rd = data_rdata; end
    end
    data_req = 1'b0;
    check("data_done_seen", 64'(seen), 64'd1);
    @(negedge clk);
    check("data_done_pulse_width", 64'(data_done), 64'd0);
    model_last_data = 1'b1;
  endtask

  task automatic fetch_txn(input logic [7:0] addr, output logic [31:0] rd, output bit seen);
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = addr;
    seen = 1'b0; rd = 32'h0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) fetch_addr = 8'($urandom);
      if (fetch_done) begin seen = 1'b1; rd = fetch_data; end
    end
    fetch_req = 1'b0;
    check("fetch_done_seen", 64'(seen), 64'd1);
    @(negedge clk);
    check("fetch_done_pulse_width", 64'(fetch_done), 64'd0);
    model_last_data = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] rd64;
    logic [31:0] rd32;
    bit seen;
    int b0, en0, dn0;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
    reset = 1'b1;
    fetch_req = 1'b0; fetch_addr = 8'h00;
    data_req = 1'b0; data_rw = 1'b0; data_size = 2'b00; data_addr = 8'h00; data_wdata = 64'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_enable", 64'(mem_enable), 64'd0);
    check("rst_done", {62'b0, fetch_done, data_done}, 64'd0);
    check("rst_mem_err", 64'(mem_err), 64'd0);
    check("rst_rdata", data_rdata, 64'h0);
    check("rst_idata", 64'(fetch_data), 64'h0);
    check("rst_mem_side", {26'b0, mem_rw, mem_address, mem_data_in, mem_size}, 64'h0);
    reset = 1'b0;

    // ---- MFC stuck low ----
    mfc_stuck = 1'b1;
    en0 = en_cycles; dn0 = done_pulses;
    @(negedge clk);
    data_req = 1'b1; data_rw = 1'b1; data_size = 2'b10; data_addr = 8'h40;
    repeat (5) @(negedge clk);
    check("stuck_enable", 64'(mem_enable), 64'd1);
`ifdef MEM_TIMEOUT_EN
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (data_done) begin
        seen = 1'b1;
        check("tmo_mem_err", 64'(mem_err), 64'd1);
        check("tmo_rdata", data_rdata, 64'h0);
      end
    end
    data_req = 1'b0;
    check("tmo_done_seen", 64'(seen), 64'd1);
    check("tmo_access_cycles", 64'(en_cycles - en0), 64'(TMO));
    @(negedge clk);
    check("tmo_err_pulse_width", 64'(mem_err), 64'd0);
    dn0 = done_pulses;
`else
    repeat (20) @(negedge clk);
    check("stuck_enable_held", 64'(mem_enable), 64'd1);
    check("stuck_enable_cycles", 64'(en_cycles - en0), 64'd25);
    check("stuck_no_done", 64'(done_pulses - dn0), 64'd0);
`endif

    // ---- reset during the access ----
    reset = 1'b1;
    data_req = 1'b0;
    @(negedge clk);
    check("midrst_enable", 64'(mem_enable), 64'd0);
    check("midrst_mem_side", {26'b0, mem_rw, mem_address, mem_data_in, mem_size}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    check("midrst_no_done", 64'(done_pulses - dn0), 64'd0);
    mfc_stuck = 1'b0;
    model_last_data = 1'b0;

    // ---- both ports held: grants must alternate, data first ----
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 8'h10;
    data_req = 1'b1; data_rw = 1'b1; data_size = 2'b10; data_addr = 8'h20;
    for (int k = 0; k < 4; k++) begin
      bit exp_data;
      exp_data = ~model_last_data;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
        @(negedge clk);
        if (fetch_done || data_done) seen = 1'b1;
      end
      check($sformatf("arb_done_seen_%0d", k), 64'(seen), 64'd1);
      check($sformatf("arb_grant_%0d", k), {62'b0, data_done, fetch_done}, exp_data ? 64'd2 : 64'd1);
      if (exp_data) check($sformatf("arb_ddata_%0d", k), data_rdata, ref_read(2'b10, 8'h20));
      else          check($sformatf("arb_idata_%0d", k), 64'(fetch_data), 64'(ref_word(8'h10)));
      model_last_data = exp_data;
      if (k == 3) begin fetch_req = 1'b0; data_req = 1'b0; end
      else begin
        if (exp_data) data_req = 1'b0; else fetch_req = 1'b0;
        @(negedge clk);
        if (exp_data) data_req = 1'b1; else fetch_req = 1'b1;
      end
    end
    repeat (3) @(negedge clk);

    // ---- directed fetch ----
    b0 = beats.size();
    fetch_txn(8'h10, rd32, seen);
    check("fetch_data_0x10", 64'(rd32), 64'h11223344);
    check("fetch_beats", 64'(beats.size() - b0), 64'd1);
    if (beats.size() > b0)
      check("fetch_size_rw", {61'b0, beats[b0].size, beats[b0].rw}, {61'b0, 2'b10, 1'b1});

    // ---- doubleword write across the top of memory ----
    b0 = beats.size();
    data_txn(1'b0, 2'b11, 8'hFC, 64'h0102030405060708, rd64, seen);
    ref_write(2'b11, 8'hFC, 64'h0102030405060708);
    check("dw_beats", 64'(beats.size() - b0), 64'd2);
    if (beats.size() >= b0 + 2) begin
      check("dw_beat0", {beats[b0].addr, beats[b0].din, beats[b0].size, beats[b0].rw},
            {8'hFC, 32'h01020304, 2'b10, 1'b0});
      check("dw_beat1", {beats[b0+1].addr, beats[b0+1].din, beats[b0+1].size, beats[b0+1].rw},
            {8'h00, 32'h05060708, 2'b10, 1'b0});
    end
    data_txn(1'b1, 2'b11, 8'hFC, 64'h0, rd64, seen);
    check("dw_readback", rd64, 64'h0102030405060708);

    // ---- stale upper DataOut bits discarded ----
    data_txn(1'b1, 2'b10, 8'h20, 64'h0, rd64, seen);
    check("word_0x20", rd64, 64'h00000000AABBCCDD);
    data_txn(1'b1, 2'b00, 8'h05, 64'h0, rd64, seen);
    check("byte_0x05", rd64, 64'h000000000000007E);

    // ---- randomized single-port traffic ----
    for (int t = 0; t < 40; t++) begin
      logic [7:0]  a;
      logic [1:0]  sz;
      logic        rw;
      logic [63:0] wd;
      a  = 8'($urandom);
      sz = 2'($urandom);
      rw = 1'($urandom);
      wd = {$urandom, $urandom};
      b0 = beats.size();
      if ($urandom_range(0, 3) == 0) begin
        fetch_txn(a, rd32, seen);
        check($sformatf("rnd%0d_fetch", t), 64'(rd32), 64'(ref_word(a)));
        check($sformatf("rnd%0d_beats", t), 64'(beats.size() - b0), 64'd1);
      end else begin
        data_txn(rw, sz, a, wd, rd64, seen);
        if (rw) check($sformatf("rnd%0d_read_sz%0d", t, sz), rd64, ref_read(sz, a));
        else    ref_write(sz, a, wd);
        check($sformatf("rnd%0d_beats", t), 64'(beats.size() - b0), (sz == 2'b11) ? 64'd2 : 64'd1);
        if (beats.size() > b0)
          check($sformatf("rnd%0d_addr", t), 64'(beats[b0].addr), 64'(a));
      end
    end

    check("never_size_11", 64'(bad_size), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
